// File: rtl/pb_seq_conditioner.sv
// pb_seq_conditioner: synchronises and debounces two board keys, then turns presses
// into one-cycle step pulses with auto-repeat and a both-keys lockout.
module pb_seq_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic key_up,
  input  logic key_dn,
  output logic pb_seq_up,
  output logic pb_seq_dn,
  output logic up_held,
  output logic dn_held
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [1:0]       RAW_IDLE   = ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_LOCKOUT
  } state_t;

  // Bit 0 is the up key, bit 1 the down key, throughout.
  logic [1:0]      w_raw;
  logic [1:0]      w_level;
  logic [1:0]      w_rise;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_deb;
  logic [1:0]      r_held;
  logic [1:0]      r_held_d;
  logic [DB_W-1:0] r_db_cnt [2];

  assign w_raw   = {key_dn, key_up};
  assign w_level = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_rise  = r_held & ~r_held_d;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      // NOTE: every register here, including the counter array, is cleared explicitly so a
      // key held through reset is re-debounced from the released state.
      r_sync1  <= RAW_IDLE;
      r_sync2  <= RAW_IDLE;
      r_deb    <= '0;
      r_held   <= '0;
      r_held_d <= '0;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the synchroniser a true two-stage pipeline.
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_held   <= r_deb;
      r_held_d <= r_held;
      for (int k = 0; k < 2; k++) begin
        if (w_level[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_deb[k]    <= ~r_deb[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic [RPT_W-1:0] w_rpt_nxt;
  logic [RPT_W-1:0] w_rpt_last;
  logic             r_active;
  logic             w_active_nxt;
  logic             w_act_held;
  logic             w_oth_held;
  logic             r_pulse_up;
  logic             r_pulse_dn;
  logic             w_pulse_up_nxt;
  logic             w_pulse_dn_nxt;

  // r_active: 0 = up key owns the repeat, 1 = down key.
  assign w_act_held = r_held[r_active];
  assign w_oth_held = r_held[~r_active];
  assign w_rpt_last = (r_state == S_DELAY) ? DELAY_LAST : RATE_LAST;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rpt_cnt  <= '0;
      r_active   <= 1'b0;
      r_pulse_up <= 1'b0;
      r_pulse_dn <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rpt_cnt  <= w_rpt_nxt;
      r_active   <= w_active_nxt;
      r_pulse_up <= w_pulse_up_nxt;
      r_pulse_dn <= w_pulse_dn_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    w_state_nxt    = r_state;
    w_rpt_nxt      = r_rpt_cnt;
    w_active_nxt   = r_active;
    w_pulse_up_nxt = 1'b0;
    w_pulse_dn_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_held[0] && r_held[1]) begin
          w_state_nxt = S_LOCKOUT;
        end else if (w_rise[0] && !r_held[1]) begin
          w_pulse_up_nxt = 1'b1;
          w_active_nxt   = 1'b0;
          w_rpt_nxt      = '0;
          w_state_nxt    = S_DELAY;
        end else if (w_rise[1] && !r_held[0]) begin
          w_pulse_dn_nxt = 1'b1;
          w_active_nxt   = 1'b1;
          w_rpt_nxt      = '0;
          w_state_nxt    = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        // Release is tested before counter expiry so a release never yields a pulse.
        if (!w_act_held) begin
          w_rpt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_oth_held) begin
          w_rpt_nxt   = '0;
          w_state_nxt = S_LOCKOUT;
        end else if (r_rpt_cnt == w_rpt_last) begin
          w_pulse_up_nxt = ~r_active;
          w_pulse_dn_nxt = r_active;
          w_rpt_nxt      = '0;
          w_state_nxt    = S_REPEAT;
        end else begin
          w_rpt_nxt = r_rpt_cnt + RPT_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (!r_held[0] && !r_held[1]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pb_seq_up = r_pulse_up;
  assign pb_seq_dn = r_pulse_dn;
  assign up_held   = r_held[0];
  assign dn_held   = r_held[1];

endmodule

// File: tb/tb_pb_seq_conditioner.sv
// Directed bench for pb_seq_conditioner: a per-cycle vector table for a single press,
// then hand-written sequences for bounce, auto-repeat, lockout and mid-repeat reset.
module tb_pb_seq_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic CLK_50 = 1'b0;
  logic reset  = 1'b1;
  logic key_up = 1'b1;
  logic key_dn = 1'b1;
  logic pb_seq_up, pb_seq_dn, up_held, dn_held;

  int n_checks    = 0;
  int n_errors    = 0;
  int cyc         = 0;
  int overlap_cnt = 0;
  int wide_cnt    = 0;
  int up_q[$];
  int dn_q[$];
  logic prev_up = 1'b0;
  logic prev_dn = 1'b0;

  typedef struct {
    logic k_up;
    logic k_dn;
    logic e_pu;
    logic e_pd;
    logic e_uh;
    logic e_dh;
  } vec_t;

  vec_t vecs[20];

  pb_seq_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .CLK_50   (CLK_50),
    .reset    (reset),
    .key_up   (key_up),
    .key_dn   (key_dn),
    .pb_seq_up(pb_seq_up),
    .pb_seq_dn(pb_seq_dn),
    .up_held  (up_held),
    .dn_held  (dn_held)
  );

  always #5 CLK_50 = ~CLK_50;

  // Edge counter plus pulse recorder; pulses are logged with the number of the edge that set them.
  always @(posedge CLK_50) begin
    cyc = cyc + 1;
    #1;
    if (pb_seq_up === 1'b1 && pb_seq_dn === 1'b1) overlap_cnt++;
    if (pb_seq_up === 1'b1 && prev_up) wide_cnt++;
    if (pb_seq_dn === 1'b1 && prev_dn) wide_cnt++;
    if (pb_seq_up === 1'b1) up_q.push_back(cyc);
    if (pb_seq_dn === 1'b1) dn_q.push_back(cyc);
    prev_up = (pb_seq_up === 1'b1);
    prev_dn = (pb_seq_dn === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input int q[$], input int exp[$]);
    check({name, "_count"}, q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < q.size()) check($sformatf("%s_edge%0d", name, i), q[i], exp[i]);
    end
  endtask

  task automatic clear_q();
    up_q.delete();
    dn_q.delete();
  endtask

  initial begin
    int e0;
    int r;
    int exp_q[$];

    // Single press held 10 cycles: vector i is applied before edge E0+i and sampled after it.
    for (int i = 0; i < 20; i++) begin
      vecs[i].k_up = (i < 10) ? 1'b0 : 1'b1;
      vecs[i].k_dn = 1'b1;
      vecs[i].e_pu = (i == 7);
      vecs[i].e_pd = 1'b0;
      vecs[i].e_uh = (i >= 6 && i < 16);
      vecs[i].e_dh = 1'b0;
    end

    reset = 1'b1;
    tick(3);
    check("rst_pb_seq_up", pb_seq_up, 0);
    check("rst_pb_seq_dn", pb_seq_dn, 0);
    check("rst_up_held", up_held, 0);
    check("rst_dn_held", dn_held, 0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 20; i++) begin
      key_up = vecs[i].k_up;
      key_dn = vecs[i].k_dn;
      tick(1);
      check($sformatf("t1_pb_seq_up_%0d", i), pb_seq_up, vecs[i].e_pu);
      check($sformatf("t1_pb_seq_dn_%0d", i), pb_seq_dn, vecs[i].e_pd);
      check($sformatf("t1_up_held_%0d", i), up_held, vecs[i].e_uh);
      check($sformatf("t1_dn_held_%0d", i), dn_held, vecs[i].e_dh);
    end
    tick(10);

    // Bouncing down key: glitches shorter than DB are ignored.
    clear_q();
    for (int b = 0; b < 2; b++) begin
      key_dn = 1'b0;
      tick(3);
      key_dn = 1'b1;
      tick(2);
    end
    key_dn = 1'b0;
    e0 = cyc + 1;
    tick(12);
    exp_q = {};
    exp_q.push_back(e0 + DB + 3);
    check_q("t2_dn", dn_q, exp_q);
    check("t2_up_none", up_q.size(), 0);
    key_dn = 1'b1;
    tick(12);
    check("t2_no_release_pulse", dn_q.size(), 1);

    // Auto-repeat; the repeat due at E0+67 coincides with the release and must be dropped.
    clear_q();
    key_up = 1'b0;
    e0 = cyc + 1;
    tick(60);
    key_up = 1'b1;
    tick(15);
    exp_q = {};
    exp_q.push_back(e0 + 7);
    for (int k = 0; k < 5; k++) exp_q.push_back(e0 + 7 + RD + k * RR);
    check_q("t3_up", up_q, exp_q);
    check("t3_dn_none", dn_q.size(), 0);

    // Down key pressed while up is in DELAY: lockout until both released.
    clear_q();
    key_up = 1'b0;
    e0 = cyc + 1;
    tick(10);
    key_dn = 1'b0;
    tick(25);
    key_up = 1'b1;
    tick(15);
    check("t4_dn_still_held", dn_held, 1);
    exp_q = {};
    exp_q.push_back(e0 + 7);
    check_q("t4_up", up_q, exp_q);
    check("t4_dn_none", dn_q.size(), 0);
    key_dn = 1'b1;
    tick(12);
    check("t4_up_after_release", up_q.size(), 1);
    check("t4_dn_after_release", dn_q.size(), 0);
    clear_q();
    key_up = 1'b0;
    e0 = cyc + 1;
    tick(10);
    key_up = 1'b1;
    tick(12);
    exp_q = {};
    exp_q.push_back(e0 + 7);
    check_q("t4_fresh_up", up_q, exp_q);

    // Both keys on the same edge: no pulses at all until both are released.
    clear_q();
    key_up = 1'b0;
    key_dn = 1'b0;
    tick(30);
    check("t5_both_held", {up_held, dn_held}, 2'b11);
    key_up = 1'b1;
    tick(15);
    check("t5_up_none", up_q.size(), 0);
    check("t5_dn_none", dn_q.size(), 0);
    key_dn = 1'b1;
    tick(12);
    check("t5_dn_none_after", dn_q.size(), 0);
    key_dn = 1'b0;
    e0 = cyc + 1;
    tick(10);
    key_dn = 1'b1;
    tick(12);
    exp_q = {};
    exp_q.push_back(e0 + 7);
    check_q("t5_fresh_dn", dn_q, exp_q);
    check("t5_fresh_up_none", up_q.size(), 0);

    // One-cycle reset during REPEAT with the up key held.
    clear_q();
    key_up = 1'b0;
    e0 = cyc + 1;
    tick(30);
    exp_q = {};
    exp_q.push_back(e0 + 7);
    exp_q.push_back(e0 + 7 + RD);
    check_q("t6_pre_reset", up_q, exp_q);
    reset = 1'b1;
    tick(1);
    r = cyc;
    check("t6_rst_pb_seq_up", pb_seq_up, 0);
    check("t6_rst_up_held", up_held, 0);
    reset = 1'b0;
    clear_q();
    tick(12);
    exp_q = {};
    exp_q.push_back(r + 1 + DB + 3);
    check_q("t6_post_reset", up_q, exp_q);
    key_up = 1'b1;
    tick(15);

    check("no_overlap", overlap_cnt, 0);
    check("one_cycle_pulses", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
